// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end. Holds the PC, issues one-outstanding read
//   requests to instruction memory, buffers returned words in a DEPTH-entry
//   prefetch queue and presents the queue head to decode via valid/ready.
//   A redirect (salto_en) flushes the queue, reloads the PC and, if a read is
//   still in flight, marks its response as stale so it is dropped on arrival.
//
// Parameters
//   DEPTH     prefetch queue entries (2..8)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   imem_req / imem_addr     read request and word-aligned address (PC)
//   imem_gnt                 memory accepted the request this cycle
//   imem_rvalid / imem_rdata one response per granted request
//   salto_en                 redirect pulse (taken branch/jump)
//   direccion_a_saltar       redirect target, bits [1:0] forced to zero
//   id_valid / id_ready      decode handshake
//   id_instr / id_pc         queue head instruction and its address
//   id_pc_plus4              id_pc + 4 (mod 2^32)
//
// Optional build macro
//   FETCH_PERF_COUNTERS_EN   adds perf_fetched, perf_flushes and
//                            perf_stall_cycles counter outputs
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        salto_en,
   input  logic [31:0] direccion_a_saltar,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [15:0] perf_flushes,
   output logic [31:0] perf_stall_cycles
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fq_entry_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_inflight_pc;
   fq_entry_t   r_q [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic        w_push;
   logic        w_pop;
   logic        w_free;
   logic        w_gnt;
   logic [CW:0] w_occ_next;
   logic [31:0] w_target;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_target = direccion_a_saltar & ~32'h3;

   // Redirect beats push: a response landing in the redirect cycle is stale.
   assign w_push = (r_state == S_WAIT) & imem_rvalid & !salto_en;
   assign w_pop  = id_valid & id_ready;

   // Occupancy after this cycle's push/pop; a new request is only issued if
   // its eventual response is guaranteed a free slot.
   assign w_occ_next = {1'b0, r_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
   assign w_free     = (w_occ_next < DEPTH_C);

   assign imem_req  = !rst & !salto_en & w_free &
                      ((r_state == S_IDLE) | ((r_state == S_WAIT) & imem_rvalid));
   assign imem_addr = r_pc;
   assign w_gnt     = imem_req & imem_gnt;

   assign id_valid    = (r_count != '0);
   assign id_instr    = r_q[r_rd_ptr].instr;
   assign id_pc       = r_q[r_rd_ptr].pc;
   assign id_pc_plus4 = id_pc + 32'd4;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // A response seen here belongs to a pre-reset request: ignore it.
            if (w_gnt) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (salto_en) begin
               // If the response arrives with the redirect it is already
               // consumed (dropped), so nothing is left to discard.
               w_state_nxt = imem_rvalid ? S_IDLE : S_DISCARD;
            end else if (imem_rvalid) begin
               w_state_nxt = w_gnt ? S_WAIT : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (imem_rvalid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ PC and queue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_inflight_pc <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
      end else begin
         if (salto_en) begin
            r_pc <= w_target;
         end else if (w_gnt) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
         end

         // A same-cycle decode handshake has already taken the head; the
         // clear discards only what is left behind it.
         if (salto_en) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_q[r_wr_ptr] <= '{instr: imem_rdata, pc: r_inflight_pc};
               r_wr_ptr      <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_occ_next[CW-1:0];
         end
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched      <= '0;
         perf_flushes      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (w_pop)                 perf_fetched      <= perf_fetched + 32'd1;
         if (salto_en)              perf_flushes      <= perf_flushes + 16'd1;
         if (id_valid && !id_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        salto_en;
   logic [31:0] direccion_a_saltar;
   logic        id_ready;

   logic        imem_req,  w2_req;
   logic [31:0] imem_addr, w2_addr;
   logic        id_valid,  w2_valid;
   logic [31:0] id_instr,  w2_instr;
   logic [31:0] id_pc,     w2_pc;
   logic [31:0] id_pc_plus4, w2_pc_plus4;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] pf_a, ps_a, pf_b, ps_b;
   logic [15:0] pl_a, pl_b;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int mem_lat  = 1;
   int pend     = -1;
   logic [31:0] pend_addr;
   int inj_req  = 0;
   int inj_seen = 0;

   always #5 clk = ~clk;

   fetch_stage #(.DEPTH(2), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .salto_en(salto_en), .direccion_a_saltar(direccion_a_saltar),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_PERF_COUNTERS_EN
      , .perf_fetched(pf_a), .perf_flushes(pl_a), .perf_stall_cycles(ps_a)
`endif
   );

   // Same stimulus, PC starting at the top of the address space (wrap check).
   fetch_stage #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) u_dut_w (
      .clk(clk), .rst(rst),
      .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .salto_en(salto_en), .direccion_a_saltar(direccion_a_saltar),
      .id_valid(w2_valid), .id_ready(id_ready), .id_instr(w2_instr),
      .id_pc(w2_pc), .id_pc_plus4(w2_pc_plus4)
`ifdef FETCH_PERF_COUNTERS_EN
      , .perf_fetched(pf_b), .perf_flushes(pl_b), .perf_stall_cycles(ps_b)
`endif
   );

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'h5A5A_0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat, input logic rdy);
      rst = 1'b1; salto_en = 1'b0; direccion_a_saltar = '0;
      id_ready = rdy; mem_lat = lat; imem_gnt = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!id_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, id_valid, 1);
   endtask

   // Redirect during WAIT (3-cycle memory); optionally a second redirect
   // while the stale response is still pending.
   task automatic redir_wait(input bit second, input logic [31:0] t2, input logic [31:0] exp);
      do_reset(3, 1'b1);
      tick();
      salto_en = 1'b1; direccion_a_saltar = 32'h0000_0043;
      #1 chk("rw_req_in_salto", imem_req, 0);
      tick();
      salto_en = 1'b0;
      #1 chk("rw_req_discard", imem_req, 0);
      chk("rw_addr_40", imem_addr, 32'h40);
      if (second) begin
         salto_en = 1'b1; direccion_a_saltar = t2;
         #1;
      end
      tick();
      salto_en = 1'b0;
      #1 chk("rw_stale_dropped", id_valid, 0);
      chk("rw_req_stale", imem_req, 0);
      tick();
      chk("rw_restart_req", imem_req, 1);
      chk("rw_restart_addr", imem_addr, exp);
      wait_valid("rw_valid_timeout");
      chk("rw_id_pc", id_pc, exp);
      chk("rw_id_instr", id_instr, memword(exp));
   endtask

   // Instruction memory: grant always follows imem_gnt, response after
   // mem_lat cycles; requests are sampled just before the rising edge.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (inj_req != inj_seen) begin
            inj_seen    = inj_req;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
         end else if (pend == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(pend_addr);
            pend        = -1;
         end else if (pend > 1) begin
            pend--;
         end
         #4;
         if (rst) pend = -1;
         else if (imem_req && imem_gnt) begin
            pend      = mem_lat;
            pend_addr = imem_addr;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; salto_en = 1'b0; direccion_a_saltar = '0;
      id_ready = 1'b0; imem_gnt = 1'b1; mem_lat = 1;

      // Reset values, first fetch, latency, wrap
      tick();
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_instr", id_instr, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_pc4", id_pc_plus4, 4);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_addr_w", w2_addr, 32'hFFFF_FFFC);
      tick();
      rst = 1'b0;
      #1 chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 0);
      tick();
      chk("lat_not_yet", id_valid, 0);
      chk("second_addr", imem_addr, 4);
      chk("wrap_addr", w2_addr, 0);
      tick();
      chk("first_valid", id_valid, 1);
      chk("first_instr", id_instr, 32'h2008_0005);
      chk("first_pc", id_pc, 0);
      chk("first_pc4", id_pc_plus4, 4);
      chk("wrap_pc", w2_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", w2_pc_plus4, 0);

      // Backpressure: two entries buffered, no further requests
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_req", imem_req, 0);
         chk("bp_instr", id_instr, 32'h2008_0005);
      end

      // Streaming: buffered words then continuous 1/cycle delivery
      id_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("st_valid", id_valid, 1);
         chk("st_pc", id_pc, 32'(4 * k));
         chk("st_instr", id_instr, memword(32'(4 * k)));
         tick();
      end

      // Redirect while waiting, then redirect again while discarding
      redir_wait(1'b0, 32'h0, 32'h40);
      redir_wait(1'b1, 32'h0000_0103, 32'h100);

      // Redirect with same-cycle handshake (head pc 8) and arriving word
      do_reset(1, 1'b1);
      tick();
      tick();
      chk("rh_pc0", id_pc, 0);
      tick();
      chk("rh_pc4", id_pc, 4);
      tick();
      chk("rh_valid8", id_valid, 1);
      chk("rh_pc8", id_pc, 8);
      chk("rh_rvalid", imem_rvalid, 1);
      salto_en = 1'b1; direccion_a_saltar = 32'h0000_0200;
      #1 chk("rh_req_salto", imem_req, 0);
      tick();
      salto_en = 1'b0;
      #1 chk("rh_flushed", id_valid, 0);
      chk("rh_req", imem_req, 1);
      chk("rh_addr", imem_addr, 32'h200);
      wait_valid("rh_valid_timeout");
      chk("rh_next_pc", id_pc, 32'h200);
      chk("rh_next_pc4", id_pc_plus4, 32'h204);
      chk("rh_next_instr", id_instr, memword(32'h200));

      // Reset mid-flight, late response ignored
      do_reset(3, 1'b0);
      repeat (4) tick();
      chk("rm_valid", id_valid, 1);
      chk("rm_instr", id_instr, 32'h2008_0005);
      chk("rm_addr", imem_addr, 8);
      rst = 1'b1;
      imem_gnt = 1'b0;
      #1 chk("rm_rst_valid", id_valid, 0);
      chk("rm_rst_instr", id_instr, 0);
      chk("rm_rst_pc", id_pc, 0);
      chk("rm_rst_pc4", id_pc_plus4, 4);
      chk("rm_rst_req", imem_req, 0);
      chk("rm_rst_addr", imem_addr, 0);
      chk("rm_rst_addr_w", w2_addr, 32'hFFFF_FFFC);
      tick();
      rst = 1'b0;
      #1 inj_req++;
      tick();
      chk("rm_late_rvalid", imem_rvalid, 1);
      chk("rm_idle_req", imem_req, 1);
      tick();
      chk("rm_late_ignored", id_valid, 0);
      imem_gnt = 1'b1;
      wait_valid("rm_valid_timeout");
      chk("rm_refetch_pc", id_pc, 0);
      chk("rm_refetch_instr", id_instr, 32'h2008_0005);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
